// File: rtl/rb_at_g_hamilton_pipe_pkg.sv
// Shared demosaic definitions: default pixel width, Bayer row phase and the
// signed-to-unsigned pixel clip used by the R/B-at-G interpolation stage.
package rb_at_g_hamilton_pipe_pkg;

  localparam int unsigned PixW = 10;

  typedef enum logic {
    PhaseB = 1'b0,
    PhaseR = 1'b1
  } bayer_phase_e;

  // Callers sign-extend into 32 bits and truncate the result back to dw bits.
  function automatic logic [31:0] clip_u(input logic signed [31:0] x, input int unsigned dw);
    logic [31:0] max_v;
    max_v = (32'd1 << dw) - 32'd1;
    if (x < 0) begin
      return '0;
    end else if (x > $signed(max_v)) begin
      return max_v;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/rb_at_g_hamilton_pipe_if.sv
// Stream interface of the R/B-at-G stage: input window beat, output R/B beat.
interface rb_at_g_hamilton_pipe_if
  import rb_at_g_hamilton_pipe_pkg::*;
#(
  parameter int unsigned DW = PixW
) ();

  logic          in_valid;
  logic          in_ready;
  logic          row_is_r;
  logic [DW-1:0] c;
  logic [DW-1:0] dn;
  logic [DW-1:0] ds;
  logic [DW-1:0] dw;
  logic [DW-1:0] de;
  logic [DW-1:0] gn;
  logic [DW-1:0] gs;
  logic [DW-1:0] gw;
  logic [DW-1:0] ge;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_b;

  modport master (
    output in_valid, row_is_r, c, dn, ds, dw, de, gn, gs, gw, ge, out_ready,
    input  in_ready, out_valid, out_r, out_b
  );

  modport slave (
    input  in_valid, row_is_r, c, dn, ds, dw, de, gn, gs, gw, ge, out_ready,
    output in_ready, out_valid, out_r, out_b
  );

endinterface

// File: rtl/rb_pipe_stage.sv
// Elastic valid/ready register slice; loads whenever empty or downstream accepts.
module rb_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  assign ready_o = !valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rb_at_g_hamilton_pipe.sv
// Three-stage Hamilton-Adams R/B interpolation at a green site with
// valid/ready backpressure and a saturating clip counter.
module rb_at_g_hamilton_pipe
  import rb_at_g_hamilton_pipe_pkg::*;
#(
  parameter int unsigned DW   = PixW,
  parameter int unsigned CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  rb_at_g_hamilton_pipe_if.slave bus,
  input  logic                   clr_cnt,
  output logic [CNTW-1:0]        clip_cnt
);

  localparam int unsigned S1W = 1 + 4 * (DW + 1);
  localparam int unsigned S2W = 1 + 2 * (DW + 2);
  localparam int unsigned S3W = 2 * DW + 2;

  logic s1_valid, s1_ready, s2_valid, s2_ready, s3_ready;

  // Stage 1: halved-neighbour sums, raw sums include the centre sample.
  logic [DW:0]    sd_h, sd_v, sg_h, sg_v;
  logic [S1W-1:0] s1_in, s1_out;
  logic           s1_row;
  logic [DW:0]    s1_sd_h, s1_sd_v, s1_sg_h, s1_sg_v;

  assign sd_h  = (DW+1)'(bus.dw >> 1) + (DW+1)'(bus.de >> 1) + (DW+1)'(bus.c);
  assign sd_v  = (DW+1)'(bus.dn >> 1) + (DW+1)'(bus.ds >> 1) + (DW+1)'(bus.c);
  assign sg_h  = (DW+1)'(bus.gw >> 1) + (DW+1)'(bus.ge >> 1);
  assign sg_v  = (DW+1)'(bus.gn >> 1) + (DW+1)'(bus.gs >> 1);
  assign s1_in = {bus.row_is_r, sd_h, sd_v, sg_h, sg_v};
  assign {s1_row, s1_sd_h, s1_sd_v, s1_sg_h, s1_sg_v} = s1_out;

  rb_pipe_stage #(.Width(S1W)) u_s1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (bus.in_valid),
    .ready_o (s1_ready),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_out)
  );

  assign bus.in_ready = s1_ready;

  // Stage 2: signed differences.
  logic signed [DW+1:0] h_d, v_d, s2_h, s2_v;
  logic [S2W-1:0]       s2_in, s2_out;
  logic                 s2_row;

  assign h_d   = $signed({1'b0, s1_sd_h}) - $signed({1'b0, s1_sg_h});
  assign v_d   = $signed({1'b0, s1_sd_v}) - $signed({1'b0, s1_sg_v});
  assign s2_in = {s1_row, h_d, v_d};
  assign {s2_row, s2_h, s2_v} = s2_out;

  rb_pipe_stage #(.Width(S2W)) u_s2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_in),
    .valid_o (s2_valid),
    .ready_i (s3_ready),
    .data_o  (s2_out)
  );

  // Stage 3: clip and route by row phase.
  bayer_phase_e   s2_phase;
  logic [DW-1:0]  clip_h, clip_v, r_d, b_d, s3_r, s3_b;
  logic           flag_h, flag_v, fr_d, fb_d, s3_fr, s3_fb;
  logic [S3W-1:0] s3_in, s3_out;

  assign s2_phase = bayer_phase_e'(s2_row);
  assign clip_h   = DW'(clip_u(32'(s2_h), DW));
  assign clip_v   = DW'(clip_u(32'(s2_v), DW));
  // Sign bit or bit DW set means out of [0, 2^DW-1].
  assign flag_h   = |s2_h[DW+1:DW];
  assign flag_v   = |s2_v[DW+1:DW];

  always_comb begin
    r_d  = clip_v;
    b_d  = clip_h;
    fr_d = flag_v;
    fb_d = flag_h;
    if (s2_phase == PhaseR) begin
      r_d  = clip_h;
      b_d  = clip_v;
      fr_d = flag_h;
      fb_d = flag_v;
    end
  end

  assign s3_in = {r_d, b_d, fr_d, fb_d};
  assign {s3_r, s3_b, s3_fr, s3_fb} = s3_out;

  rb_pipe_stage #(.Width(S3W)) u_s3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (s2_valid),
    .ready_o (s3_ready),
    .data_i  (s3_in),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (s3_out)
  );

  assign bus.out_r = s3_r;
  assign bus.out_b = s3_b;

  // Saturating clip counter; clear has priority over a coincident handshake.
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW:0]   cnt_sum;
  logic [1:0]      n_clip;
  logic            fire;

  assign fire    = bus.out_valid & bus.out_ready;
  assign n_clip  = {1'b0, s3_fr} + {1'b0, s3_fb};
  assign cnt_sum = {1'b0, cnt_q} + (CNTW+1)'(n_clip);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign clip_cnt = cnt_q;

endmodule

// File: doc/rb_at_g_hamilton_pipe.md
# rb_at_g_hamilton_pipe

Pipelined, parametrised Hamilton-Adams interpolation of the missing R and B values at a green Bayer site. It replaces the combinational R/B-at-G stage in the demosaic datapath, sitting after the G-at-R/B stage that supplies the four interpolated greens. The block adds valid/ready flow control with backpressure, a per-pixel row-phase select that routes results to `out_r`/`out_b`, and a saturating clip counter for image-quality monitoring.

## Interface
- `DW`, 10, pixel width in bits, all data ports.
- `CNTW`, 16, width of the clip counter.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `row_is_r`  in  1  1: centre G lies in an R row (horizontal neighbours are R); 0: B row.
- `c`  in  DW  raw centre G sample (window position 4,4).
- `dn`, `ds`, `dw`, `de`  in  DW each  raw neighbours north/south/west/east (D34, D54, D43, D45).
- `gn`, `gs`, `gw`, `ge`  in  DW each  interpolated green at those four neighbour sites.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_r`, `out_b`  out  DW each  clipped interpolated red/blue.
- `clr_cnt`  in  1  synchronous clear of `clip_cnt`.
- `clip_cnt`  out  CNTW  count of clipped channel results, saturating.

## Operation
- H = (dw>>1) + (de>>1) + c − (gw>>1) − (ge>>1); V = same with dn/ds/gn/gs. Each `>>1` floors; evaluated in signed DW+2 bits (range −(2^DW−1)…2^(DW+1)−2, no overflow).
- Clip per channel: negative → 0; ≥ 2^DW → 2^DW−1; else low DW bits.
- Routing: `row_is_r`=1 → `out_r`=clip(H), `out_b`=clip(V); `row_is_r`=0 → `out_b`=clip(H), `out_r`=clip(V). `row_is_r` travels with its beat.
- Stage 1 (S1): register halved-neighbour sums ΣD_H, ΣD_V (DW+1 bits, plus c → DW+1) and ΣG_H, ΣG_V.
- Stage 2 (S2): register signed differences H, V (DW+2).
- Stage 3 (S3): clip, route, register `out_r`, `out_b`, plus clip flags.
- Elastic pipeline: each stage holds valid bit v_k; stage k loads when ready_k = !v_k | ready_{k+1}; ready_4 = `out_ready`; `in_ready` = ready_1. Bubbles collapse; no beat dropped or duplicated.
- Counter: on each output handshake (`out_valid` & `out_ready`) add number of clipped channels (0, 1 or 2); saturate at 2^CNTW−1, never wraps. `clr_cnt` same cycle as handshake → result 0 (clear wins).

## Timing
- Latency 3 cycles from input handshake to `out_valid` with no stall; throughput 1 beat/cycle.
- `out_valid` & `out_r`/`out_b` stay stable while `out_valid` & !`out_ready`.
- `in_ready` is combinational from `out_ready` through the ready chain; no combinational path from data to valid/ready.
- Pipeline full (3 beats) and `out_ready`=0 → `in_ready`=0.
- Simultaneous output drain and input accept when full → all stages shift, `in_ready`=1.
- Reset (any cycle, incl. mid-stream): all v_k=0, `out_valid`=0, `out_r`=`out_b`=0, `clip_cnt`=0, `in_ready`=1 after release; in-flight beats discarded.

## Structure
- Shared demosaic package: pixel width default, `clip_u` function (signed DW+2 → unsigned DW), Bayer phase enum.
- One sub-module natural: `rb_pipe_stage` (valid/ready register slice, parametrised payload width), instantiated three times; arithmetic stays in the top.

## Test plan
- DW=10, row_is_r=0, c=512, dw=de=400, gw=ge=300, dn=ds=100, gn=gs=800 → after 3 cycles out_b=612, out_r=0, clip_cnt=1.
- Same beat with row_is_r=1 → out_r=612, out_b=0.
- c=dw=de=dn=ds=1023, all g=0 → out_r=out_b=1023, clip_cnt +2; odd values check flooring (dw=de=1, g=0, c=0 → 0).
- Stream 20 random beats, out_ready toggled pseudo-randomly → outputs match reference model in order, none lost; out_ready held 0 → in_ready drops after 3 accepts, outputs stable.
- Preload clip_cnt near 2^CNTW−1 with clipping beats → holds at 65535; clr_cnt coincident with clipping handshake → 0.
- Assert rst with 2 beats in flight → out_valid=0 immediately, counter 0, next beat emerges with 3-cycle latency.
